// File: rtl/mult_pkg.sv
// Shared defaults and FSM state encoding for the round-robin multiplier scheduler.
package mult_pkg;
    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/shift_add_core.sv
// Sequential add-shift multiplier: loads operands on start, iterates N cycles,
// and flags the final iteration with done while product shows the finished sum.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           running;
    logic [2*N-1:0] addend;

    // product is the accumulator value after the current iteration, so it is
    // already complete during the cycle done is high.
    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        product = acc + addend;
        done    = running && (cnt == CW'(N - 1));
    end

    // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{N{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter and control FSM sharing one add-shift multiplier among
// NREQ requesters; one product per N+2 cycles, tagged with the owner's index.
module mult_scheduler
    import mult_pkg::*;
#(
    parameter int  N    = DEF_N,
    parameter int  NREQ = DEF_NREQ,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] a_in,
    input  logic [NREQ*N-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [2*N-1:0]    out,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id
);
    state_t         state;
    logic [IDW-1:0] last_winner;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cur_id;
    logic           found;
    logic           grant;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    logic           core_done;
    logic [2*N-1:0] core_product;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last_winner;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last_winner) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(last_winner) + k) % NREQ);
            end
        end
    end

    assign grant = (state == IDLE) && found;
    assign a_sel = a_in[winner*N +: N];
    assign b_sel = b_in[winner*N +: N];
    assign busy  = (state != IDLE);

    // The grant must coincide with the IDLE decision cycle, so it is decoded
    // rather than registered; reset masks it immediately.
    always_comb begin
        gnt = '0;
        if (grant && !reset)
            gnt[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= IDW'(NREQ - 1);
            cur_id      <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            out_id      <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    last_winner <= winner;
                    cur_id      <= winner;
                    state       <= RUN;
                end
                RUN: if (core_done) begin
                    out       <= core_product;
                    out_id    <= cur_id;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operands are captured into the core's shift registers on the grant edge.
    shift_add_core #(.N(N)) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (grant),
        .a       (a_sel),
        .b       (b_sel),
        .done    (core_done),
        .product (core_product)
    );
endmodule

// File: tb/tb_mult_scheduler.sv
// Directed and randomized checks of mult_scheduler against a behavioural model:
// round-robin order, exact products, latency, spacing, and reset abort.
module tb_mult_scheduler;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_in;
    logic [NREQ*N-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [2*N-1:0]    out;
    logic              out_valid;
    logic [IDW-1:0]    out_id;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int model_last  = NREQ - 1;
    int last_gnt    = -1;

    mult_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index after the last winner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [NREQ*N-1:0] rand_ops();
        logic [NREQ*N-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*N +: N] = N'($urandom);
        return v;
    endfunction

    function automatic logic [NREQ*N-1:0] op0(input logic [N-1:0] x);
        logic [NREQ*N-1:0] v;
        v = rand_ops();
        v[N-1:0] = x;
        return v;
    endfunction

    // One complete transaction: present r with operands, expect the model's
    // winner, then scramble operands and hold r_next through RUN/DONE.
    task automatic job(input logic [NREQ-1:0] r, input logic [NREQ*N-1:0] av,
                       input logic [NREQ*N-1:0] bv, input logic [NREQ-1:0] r_next);
        int             w;
        int             k;
        int             gc;
        bit             quiet;
        logic [2*N-1:0] exp_p;
        logic [NREQ-1:0] exp_g;
        w     = rr_pick(r, model_last);
        exp_g = '0;
        exp_g[w] = 1'b1;
        req  = r;
        a_in = av;
        b_in = bv;
        #1;
        k = 0;
        while (gnt == '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("gnt", gnt, exp_g);
        if (gnt == '0) begin
            last_gnt = -1;
            return;
        end
        gc = cyc;
        if (last_gnt >= 0) check("spacing", gc - last_gnt, N + 2);
        model_last = w;
        exp_p = (2*N)'(av[w*N +: N]) * (2*N)'(bv[w*N +: N]);
        @(posedge clk);
        #1;
        req  = r_next;
        a_in = rand_ops();
        b_in = rand_ops();
        quiet = 1'b1;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            if (gnt !== '0 || busy !== 1'b1 || out_valid !== 1'b0) quiet = 1'b0;
        end
        check("run_quiet", quiet, 1);
        @(negedge clk);
        check("out_valid", out_valid, 1);
        check("out", out, exp_p);
        check("out_id", out_id, w);
        @(negedge clk);
        check("valid_pulse", out_valid, 0);
        check("out_hold", out, exp_p);
        check("busy_idle", busy, 0);
        last_gnt = gc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        model_last = NREQ - 1;
        last_gnt   = -1;
        @(negedge clk);
    endtask

    initial begin
        bit quiet;
        logic [NREQ-1:0] r;
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        req = '1;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_id", out_id, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = '0;
        @(negedge clk);

        // Directed products on requester 0, including the extremes.
        job(4'b0001, op0(8'd13), op0(8'd11), 4'b0000);
        job(4'b0001, op0(8'd255), op0(8'd255), 4'b0000);
        job(4'b0001, op0(8'd0), op0(8'd200), 4'b0000);
        job(4'b0001, op0(8'd1), op0(8'd1), 4'b0000);

        // All requesters held: 0,1,2,3,0,1,2,3 at N+2 spacing, then wrap with 1001.
        do_reset();
        for (int i = 0; i < 8; i++) job(4'b1111, rand_ops(), rand_ops(), 4'b1111);
        job(4'b1001, rand_ops(), rand_ops(), 4'b0000);

        // Reset four cycles into RUN aborts the operation silently.
        req  = 4'b0001;
        a_in = op0(8'd77);
        b_in = op0(8'd91);
        #1;
        check("abort_gnt", gnt, 4'b0001);
        @(posedge clk);
        #1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_gnt0", gnt, 0);
        check("abort_busy0", busy, 0);
        check("abort_out0", out, 0);
        check("abort_valid0", out_valid, 0);
        check("abort_id0", out_id, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        model_last = NREQ - 1;
        last_gnt   = -1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("abort_quiet", quiet, 1);
        job(4'b0100, rand_ops(), rand_ops(), 4'b0000);

        // Operand churn and req1 during requester 0's run.
        job(4'b0001, rand_ops(), rand_ops(), 4'b0010);
        job(4'b0010, rand_ops(), rand_ops(), 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            job(r, rand_ops(), rand_ops(), ($urandom % 2) ? r : NREQ'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter N, default 8, sets the operand width in bits.
REQ-002 Parameter NREQ, default 4, sets the requester count (>=2).
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  level request per requester; bit i = requester i.
REQ-006 a_in  input  NREQ*N  packed multiplicands; slice [i*N +: N] belongs to requester i.
REQ-007 b_in  input  NREQ*N  packed multipliers; same slicing as a_in.
REQ-008 gnt  output  NREQ  one-hot grant, one-cycle pulse.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 out  output  2N  unsigned product.
REQ-011 out_valid  output  1  one-cycle pulse qualifying out and out_id.
REQ-012 out_id  output  clog2(NREQ)  index of the requester that owns out.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE only.
REQ-014 In IDLE with req!=0: pick a winner round-robin, starting at (last_winner+1) mod NREQ, wrapping.
REQ-015 In that same cycle, pulse gnt[winner], latch the winner's a/b slices and id, clear the accumulator and go to RUN.
REQ-016 In IDLE with req==0: gnt=0, and last_winner is unchanged.
REQ-017 RUN SHALL take exactly N cycles, with an iteration counter running 0..N-1.
REQ-018 Each RUN cycle: if multiplier LSB=1, add the multiplicand into the accumulator; shift the multiplicand left 1 and the multiplier right 1.
REQ-019 After iteration N-1: go to DONE.
REQ-020 In DONE: out_valid=1 and out_id=latched id for one cycle, then return to IDLE.
REQ-021 Latency: out_valid SHALL rise exactly N+1 cycles after the gnt cycle.
REQ-022 Back-to-back throughput: one product per N+2 cycles.
REQ-023 req during RUN/DONE SHALL be ignored (no gnt); requests are held by the requester, not queued.
REQ-024 A requester still asserting req after its grant is re-arbitrated normally and gets no priority.
REQ-025 Operand changes after grant SHALL NOT affect the in-flight product.
REQ-026 Product SHALL be exact unsigned a*b in 2N bits; the accumulator is 2N bits wide with no overflow possible.
REQ-027 out SHALL hold the last product until the next DONE; out_id likewise.

Reset
REQ-028 Reset asserted SHALL immediately force state=IDLE, gnt=0, busy=0, out=0, out_valid=0, out_id=0, counter=0, last_winner=NREQ-1.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse.
REQ-030 After reset, requester 0 has highest priority.

Structure
REQ-031 A shared package mult_pkg SHALL hold the default N, the default NREQ, and the state encoding constants.
REQ-032 The add-shift datapath (accumulator, shift registers, counter) SHALL be the sub-module shift_add_core, with ports start, done and product.
REQ-033 mult_scheduler SHALL contain only the arbiter, FSM and operand/id latches.

Verification
REQ-034 req=0001, a0=13, b0=11 -> gnt=0001 at cycle T; out_valid at T+9; out=143; out_id=0.
REQ-035 req0 with a=255, b=255 -> out=65025; req0 with a=0, b=200 -> out=0; a=1, b=1 -> out=1.
REQ-036 req=1111 held after reset -> grants in order 0,1,2,3,0, spaced 10 cycles apart, with matching out_id.
REQ-037 After requester 3 is granted, req=1001 -> next grant is requester 0 (wrap).
REQ-038 reset pulsed 4 cycles into RUN -> all outputs 0, no out_valid; a following req2 grants requester 2 correctly.
REQ-039 Change a_in/b_in and assert req1 during RUN for requester 0 -> requester 0's product is unchanged; requester 1 is granted the cycle after DONE.
